// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver that samples mid-bit, rejects short start glitches and parks in BREAK after a bad stop bit.
// Optional macro UART_RX_MAJORITY_EN replaces each decision sample with a 3-sample majority vote.
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 200000000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [31:0] TIMER_MAX = 32'(CLOCK_FREQUENCY / BAUD_RATE - 1);
  localparam logic [31:0] HALF      = TIMER_MAX / 32'd2;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic [31:0] count;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        sync1;
  logic        rx_s;
  logic        sample;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[0] tracks rx_s, so the vote covers rx_s at this edge and the two before it.
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (!rstn) hist <= 3'b111;
    else       hist <= {hist[1:0], sync1};
  end

  assign sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      count     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      dout      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          // A start bit that is high again at its midpoint was only a glitch.
          if (count == HALF) begin
            if (!sample) begin
              state   <= DATA;
              count   <= '0;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + 32'd1;
          end
        end
        DATA: begin
          if (count == TIMER_MAX) begin
            shift_reg[bit_idx] <= sample;
            count              <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            count <= count + 32'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start bit be caught on time.
          if (count == TIMER_MAX) begin
            count <= '0;
            if (sample) begin
              dout  <= shift_reg;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            count <= count + 32'd1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit (TIMER_MAX=15, HALF=7).
// Expected frames go into a scoreboard queue when driven and are checked when valid or frame_err pulses.
module tb_uart_rx;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .dout(dout),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int BIT     = 16;
  localparam int LATENCY = 7 + 3 + 9 * 16;
  localparam int FRAME   = 10 * BIT;

  typedef struct {
    logic [7:0] data;
    logic       isErr;
    int         startCyc;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         gapAfter;
    logic [7:0] expData;
    logic       expErr;
  } vec_t;

  exp_t       expQ[$];
  exp_t       popped;
  int         validCycs[$];
  int         tests      = 0;
  int         fails      = 0;
  int         cyc        = 0;
  int         pulseCount = 0;
  logic [7:0] expDout    = 8'h00;
  bit         resetSeen  = 1'b1;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    resetSeen <= !rstn;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Scoreboard side: every pulse must match the oldest pending frame, and dout must hold otherwise.
  always @(negedge clk) begin
    if (resetSeen) begin
      expDout = 8'h00;
      checkOutput("reset dout", dout, 8'h00);
      checkOutput("reset valid", valid, 1'b0);
      checkOutput("reset frame_err", frame_err, 1'b0);
      checkOutput("reset busy", busy, 1'b0);
    end else if (valid === 1'b1 || frame_err === 1'b1) begin
      pulseCount++;
      checkOutput("pulse overlap", valid & frame_err, 1'b0);
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected pulse: valid=%0b frame_err=%0b, expected no pulse", valid, frame_err);
      end else begin
        popped = expQ.pop_front();
        checkOutput("pulse kind frame_err", frame_err, popped.isErr);
        checkOutput("pulse latency", cyc - popped.startCyc, LATENCY);
        if (!popped.isErr) begin
          checkOutput("dout on valid", dout, popped.data);
          expDout = popped.data;
          validCycs.push_back(cyc);
        end else begin
          checkOutput("dout after frame_err", dout, expDout);
        end
      end
    end else begin
      checkOutput("dout hold", dout, expDout);
    end
  end

  task automatic sendBit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit glitch,
                               input logic [7:0] expData, input logic expErr);
    exp_t e;
    e.data     = expData;
    e.isErr    = expErr;
    e.startCyc = cyc + 1;
    expQ.push_back(e);
    sendBit(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (glitch) begin
        sendBit(data[i], 8);
        sendBit(!data[i], 1);
        sendBit(data[i], 7);
      end else begin
        sendBit(data[i], BIT);
      end
    end
    sendBit(stopBit, BIT);
  endtask

  initial begin
    vec_t       vecs[6];
    int         pc;
    logic [7:0] glitchExp;

    vecs[0] = '{8'hA5, 1'b1, 20, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0,  8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 30, 8'h3C, 1'b0};
    vecs[4] = '{8'h6E, 1'b0, 20, 8'h6E, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 10, 8'h01, 1'b0};

    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    sendBit(1'b1, 10);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stopBit, 1'b0, vecs[i].expData, vecs[i].expErr);
      checkOutput("busy at frame end", busy, vecs[i].expErr);
      sendBit(1'b1, vecs[i].gapAfter);
    end
    sendBit(1'b1, 5);
    checkOutput("pending after table", expQ.size(), 0);
    checkOutput("valid count after table", validCycs.size(), 5);
    if (validCycs.size() >= 4) begin
      checkOutput("back-to-back spacing 1", validCycs[2] - validCycs[1], FRAME);
      checkOutput("back-to-back spacing 2", validCycs[3] - validCycs[2], FRAME);
    end

    // Short low pulse on an idle line must be discarded at the start-bit midpoint.
    pc = pulseCount;
    sendBit(1'b0, 4);
    sendBit(1'b1, 4);
    checkOutput("busy during start glitch", busy, 1'b1);
    sendBit(1'b1, 26);
    checkOutput("busy after start glitch", busy, 1'b0);
    checkOutput("pulses after start glitch", pulseCount, pc);

    // Bad stop bit with the line held low 40 clocks total, then recovery.
    applyStimulus(8'h55, 1'b0, 1'b0, 8'h55, 1'b1);
    sendBit(1'b0, 24);
    checkOutput("busy in break", busy, 1'b1);
    sendBit(1'b1, 4);
    checkOutput("busy after break", busy, 1'b0);
    sendBit(1'b1, 10);
    applyStimulus(8'h12, 1'b1, 1'b0, 8'h12, 1'b0);
    sendBit(1'b1, 10);
    checkOutput("dout after break recovery", dout, 8'h12);

    // Reset pulse in the middle of bit 4 of 0x81.
    sendBit(1'b0, BIT);
    sendBit(1'b1, BIT);
    sendBit(1'b0, BIT);
    sendBit(1'b0, BIT);
    sendBit(1'b0, BIT);
    sendBit(1'b0, 8);
    rx   = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("dout after mid-frame reset", dout, 8'h00);
    checkOutput("busy after mid-frame reset", busy, 1'b0);
    pc = pulseCount;
    sendBit(1'b1, 40);
    checkOutput("pulses after mid-frame reset", pulseCount, pc);
    checkOutput("busy idle after reset", busy, 1'b0);
    applyStimulus(8'h81, 1'b1, 1'b0, 8'h81, 1'b0);
    sendBit(1'b1, 10);
    checkOutput("dout after reset recovery", dout, 8'h81);

    // One-clock inverted glitch at every data sample point.
`ifdef UART_RX_MAJORITY_EN
    glitchExp = 8'hC3;
`else
    glitchExp = 8'h3C;
`endif
    applyStimulus(8'hC3, 1'b1, 1'b1, glitchExp, 1'b0);
    sendBit(1'b1, 10);
    checkOutput("dout after sample glitches", dout, glitchExp);

    checkOutput("pending at end", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
